// File: rtl/rotate_scheduler.sv
// rotate_scheduler: front-end sequencer for the CORDIC rotation core.
// Accepts points on a valid/ready stream, folds full-circle angles into the
// +/- pi/2 range the core handles, issues one start per point, captures the
// one-cycle core result and holds it on a backpressured output stream.
module rotate_scheduler #(
  parameter int DATA_WIDTH       = 7,
  parameter int ANGLE_WIDTH      = 23,
  parameter int CORE_ANGLE_WIDTH = 22,
  parameter int TIMEOUT          = 32
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_valid,
  output logic                               o_ready,
  input  logic signed [DATA_WIDTH-1:0]       i_x,
  input  logic signed [DATA_WIDTH-1:0]       i_y,
  input  logic signed [ANGLE_WIDTH-1:0]      i_angle,
  output logic                               o_cordic_start,
  output logic signed [DATA_WIDTH-1:0]       o_cordic_x,
  output logic signed [DATA_WIDTH-1:0]       o_cordic_y,
  output logic signed [CORE_ANGLE_WIDTH-1:0] o_cordic_angle,
  input  logic signed [DATA_WIDTH-1:0]       i_cordic_x,
  input  logic signed [DATA_WIDTH-1:0]       i_cordic_y,
  input  logic                               i_cordic_done,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic signed [DATA_WIDTH-1:0]       o_x,
  output logic signed [DATA_WIDTH-1:0]       o_y,
  output logic [15:0]                        o_count,
  output logic                               o_error
);

  localparam int TW = $clog2(TIMEOUT + 1);

  // Angle constants in 2^-20 rad units, held one bit wider than the input
  // so the fold arithmetic cannot overflow.
  localparam logic signed [ANGLE_WIDTH:0] PI_Q   = (ANGLE_WIDTH+1)'(3294199);
  localparam logic signed [ANGLE_WIDTH:0] NPI_Q  = -PI_Q;
  localparam logic signed [ANGLE_WIDTH:0] HPI_Q  = (ANGLE_WIDTH+1)'(1647099);
  localparam logic signed [ANGLE_WIDTH:0] NHPI_Q = -HPI_Q;

  localparam logic signed [DATA_WIDTH-1:0] MIN_D = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] MAX_D = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

  // Two's-complement negation that maps the most negative code to the
  // most positive one instead of wrapping back onto itself.
  function automatic logic signed [DATA_WIDTH-1:0] sat_neg(
    input logic signed [DATA_WIDTH-1:0] v
  );
    if (v == MIN_D) return MAX_D;
    return -v;
  endfunction

  state_t                         state_q, state_d;
  logic                           ready_q, ready_d;
  logic                           start_q, start_d;
  logic                           valid_q, valid_d;
  logic signed [DATA_WIDTH-1:0]   cx_q, cx_d, cy_q, cy_d;
  logic signed [CORE_ANGLE_WIDTH-1:0] ca_q, ca_d;
  logic signed [DATA_WIDTH-1:0]   ox_q, ox_d, oy_q, oy_d;
  logic [15:0]                    count_q, count_d;
  logic                           error_q, error_d;
  logic [TW-1:0]                  timer_q, timer_d;

  logic signed [ANGLE_WIDTH:0]    a_ext, a_clamp, a_fold;
  logic                           fold_flip;

  // Clamp the incoming angle to [-pi, pi] and fold it into [-pi/2, pi/2];
  // a half-turn of the angle is compensated by negating the point.
  always_comb begin
    a_ext     = {i_angle[ANGLE_WIDTH-1], i_angle};
    a_clamp   = a_ext;
    a_fold    = a_ext;
    fold_flip = 1'b0;
    if (a_ext > PI_Q)       a_clamp = PI_Q;
    else if (a_ext < NPI_Q) a_clamp = NPI_Q;
    a_fold = a_clamp;
    if (a_clamp > HPI_Q) begin
      a_fold    = a_clamp - PI_Q;
      fold_flip = 1'b1;
    end else if (a_clamp < NHPI_Q) begin
      a_fold    = a_clamp + PI_Q;
      fold_flip = 1'b1;
    end
  end

  // Next-state and next-output logic; every output is a flop whose next
  // value is derived from the next state, so nothing is combinational.
  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    ca_d    = ca_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    count_d = count_q;
    error_d = error_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          cx_d    = fold_flip ? sat_neg(i_x) : i_x;
          cy_d    = fold_flip ? sat_neg(i_y) : i_y;
          ca_d    = CORE_ANGLE_WIDTH'(a_fold);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving in the timeout cycle still wins.
        if (i_cordic_done) begin
          ox_d    = i_cordic_x;
          oy_d    = i_cordic_y;
          state_d = S_OUT;
        end else if (timer_q == TIMER_LAST) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_OUT: begin
        if (i_ready) begin
          count_d = count_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    start_d = (state_d == S_ISSUE);
    valid_d = (state_d == S_OUT);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      ca_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      count_q <= '0;
      error_q <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      start_q <= start_d;
      valid_q <= valid_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      ca_q    <= ca_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      count_q <= count_d;
      error_q <= error_d;
      timer_q <= timer_d;
    end
  end

  assign o_ready        = ready_q;
  assign o_cordic_start = start_q;
  assign o_cordic_x     = cx_q;
  assign o_cordic_y     = cy_q;
  assign o_cordic_angle = ca_q;
  assign o_valid        = valid_q;
  assign o_x            = ox_q;
  assign o_y            = oy_q;
  assign o_count        = count_q;
  assign o_error        = error_q;

endmodule

// File: tb/tb_rotate_scheduler.sv
// Testbench for rotate_scheduler: randomized points against a geometric
// reference model, with a scoreboard for core operands and output points.
module tb_rotate_scheduler;

  localparam int DW    = 7;
  localparam int AW    = 23;
  localparam int CAW   = 22;
  localparam int TO    = 32;
  localparam int PI_Q  = 3294199;
  localparam int HPI_Q = 1647099;

  logic                  i_clk = 1'b0;
  logic                  i_rst_n = 1'b1;
  logic                  i_valid = 1'b0;
  logic                  o_ready;
  logic signed [DW-1:0]  i_x = '0, i_y = '0;
  logic signed [AW-1:0]  i_angle = '0;
  logic                  o_cordic_start;
  logic signed [DW-1:0]  o_cordic_x, o_cordic_y;
  logic signed [CAW-1:0] o_cordic_angle;
  logic signed [DW-1:0]  i_cordic_x, i_cordic_y;
  logic                  i_cordic_done;
  logic                  o_valid;
  logic                  i_ready;
  logic signed [DW-1:0]  o_x, o_y;
  logic [15:0]           o_count;
  logic                  o_error;

  rotate_scheduler #(
    .DATA_WIDTH(DW), .ANGLE_WIDTH(AW), .CORE_ANGLE_WIDTH(CAW), .TIMEOUT(TO)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_x(i_x), .i_y(i_y), .i_angle(i_angle),
    .o_cordic_start(o_cordic_start), .o_cordic_x(o_cordic_x),
    .o_cordic_y(o_cordic_y), .o_cordic_angle(o_cordic_angle),
    .i_cordic_x(i_cordic_x), .i_cordic_y(i_cordic_y),
    .i_cordic_done(i_cordic_done), .o_valid(o_valid), .i_ready(i_ready),
    .o_x(o_x), .o_y(o_y), .o_count(o_count), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { int x; int y; int a; } op_t;
  typedef struct { int x; int y; } pt_t;

  op_t op_q[$];
  pt_t out_q[$];
  int  checks = 0;
  int  failures = 0;
  int  delivered = 0;
  int  cnt_base = 0;
  bit  core_disable = 1'b0;
  bit  rdy_mode = 1'b1;
  logic rdy_val = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input int act, input int exp);
    checks++;
    if (act > exp + 1 || act < exp - 1) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d(+/-1)", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 63) return 63;
    if (v < -64) return -64;
    return v;
  endfunction

  function automatic int clamp_a(input int a);
    if (a > PI_Q) return PI_Q;
    if (a < -PI_Q) return -PI_Q;
    return a;
  endfunction

  // Reference fold: a half-turn of the angle equals negating the point.
  function automatic op_t fold(input int x, input int y, input int a);
    op_t r;
    int  c;
    c = clamp_a(a);
    r.x = x; r.y = y; r.a = c;
    if (c > HPI_Q) begin
      r.a = c - PI_Q; r.x = sat(-x); r.y = sat(-y);
    end else if (c < -HPI_Q) begin
      r.a = c + PI_Q; r.x = sat(-x); r.y = sat(-y);
    end
    return r;
  endfunction

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  // Ideal rotation of a point by an angle in 2^-20 rad units.
  function automatic pt_t rot(input int x, input int y, input int a);
    pt_t p;
    real th;
    th  = real'(a) / 1048576.0;
    p.x = sat(rnd(real'(x) * $cos(th) - real'(y) * $sin(th)));
    p.y = sat(rnd(real'(x) * $sin(th) + real'(y) * $cos(th)));
    return p;
  endfunction

  // Downstream ready: random or forced by the main sequence.
  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #2;
      i_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_val;
    end
  end

  // Rotation core model: answers each start with a one-cycle done pulse.
  initial begin
    i_cordic_done = 1'b0;
    i_cordic_x = '0;
    i_cordic_y = '0;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_cordic_start && !core_disable) begin
        pt_t r;
        r = rot(int'(o_cordic_x), int'(o_cordic_y), int'(o_cordic_angle));
        repeat (16) @(posedge i_clk);
        #1;
        i_cordic_done = 1'b1;
        i_cordic_x = DW'(r.x);
        i_cordic_y = DW'(r.y);
        @(posedge i_clk);
        #1;
        i_cordic_done = 1'b0;
        i_cordic_x = '0;
        i_cordic_y = '0;
      end
    end
  end

  // Operand monitor: every start pulse must carry the expected folded point.
  initial begin
    bit prev_start;
    prev_start = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_cordic_start) begin
        if (prev_start) check("start_one_cycle", 1, 0);
        if (op_q.size() == 0) check("unexpected_start", 1, 0);
        else begin
          op_t e;
          e = op_q.pop_front();
          check("cordic_x", int'(o_cordic_x), e.x);
          check("cordic_y", int'(o_cordic_y), e.y);
          check("cordic_angle", int'(o_cordic_angle), e.a);
        end
      end
      prev_start = o_cordic_start;
    end
  end

  // Output monitor: pops the expected point on each delivery.
  initial begin
    bit pend_cnt;
    pend_cnt = 1'b0;
    forever begin
      @(negedge i_clk);
      if (pend_cnt && i_rst_n)
        check("o_count", int'(o_count), (delivered - cnt_base) & 16'hFFFF);
      pend_cnt = 1'b0;
      if (i_rst_n && o_valid && i_ready) begin
        if (out_q.size() == 0) check("unexpected_output", 1, 0);
        else begin
          pt_t e;
          e = out_q.pop_front();
          check_tol("out_x", int'(o_x), e.x);
          check_tol("out_y", int'(o_y), e.y);
        end
        delivered++;
        pend_cnt = 1'b1;
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, int'(o_ready), 1);
    check({tag, "_valid"}, int'(o_valid), 0);
    check({tag, "_start"}, int'(o_cordic_start), 0);
    check({tag, "_cx"}, int'(o_cordic_x), 0);
    check({tag, "_cy"}, int'(o_cordic_y), 0);
    check({tag, "_ca"}, int'(o_cordic_angle), 0);
    check({tag, "_ox"}, int'(o_x), 0);
    check({tag, "_oy"}, int'(o_y), 0);
    check({tag, "_count"}, int'(o_count), 0);
    check({tag, "_error"}, int'(o_error), 0);
  endtask

  // Present one point; called at 1 time unit after a rising edge.
  task automatic send(input int x, input int y, input int a, input bit exp_out);
    int n;
    n = 0;
    while (!o_ready && n < 400) begin
      @(posedge i_clk); #1; n++;
    end
    if (n >= 400) begin
      check("ready_wait_bound", n, 0);
      return;
    end
    op_q.push_back(fold(x, y, a));
    if (exp_out) out_q.push_back(rot(x, y, clamp_a(a)));
    i_valid = 1'b1;
    i_x = DW'(x); i_y = DW'(y); i_angle = AW'(a);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((out_q.size() != 0 || op_q.size() != 0) && n < 3000) begin
      @(posedge i_clk); #1; n++;
    end
    check("drain_bound", int'(n >= 3000), 0);
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (!o_cordic_start && n < 400) begin
      @(posedge i_clk); #1; n++;
    end
    check("start_wait_bound", int'(n >= 400), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt0, sx, sy;
    #1 i_rst_n = 1'b0;
    #2 check_reset("rst_async");
    repeat (2) @(posedge i_clk);
    #1 check_reset("rst_held");
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Directed points from the rotation corner cases.
    send(40, 0, 0, 1);
    send(40, 0, PI_Q, 1);
    send(10, 20, -2097152, 1);
    send(-64, 5, PI_Q, 1);
    send(12, -7, HPI_Q, 1);
    send(12, -7, -HPI_Q, 1);
    send(-20, 30, HPI_Q + 1, 1);
    send(25, 3, -HPI_Q - 1, 1);
    send(9, 9, PI_Q + 500000, 1);
    send(-9, 33, -PI_Q - 700000, 1);
    drain();
    check("count_directed", int'(o_count), 10);

    // Randomized points, angles spanning beyond the clamp limits.
    for (int i = 0; i < 30; i++) begin
      int rx, ry, ra;
      rx = int'($urandom_range(0, 80)) - 40;
      ry = int'($urandom_range(0, 80)) - 40;
      ra = int'($urandom_range(0, 2 * PI_Q + 600000)) - PI_Q - 300000;
      send(rx, ry, ra, 1);
    end
    drain();
    check("count_random", int'(o_count), 40);

    // Backpressure: output must hold while downstream is not ready.
    rdy_mode = 1'b0;
    rdy_val = 1'b0;
    send(17, -9, 500000, 1);
    n = 0;
    while (!o_valid && n < 400) begin
      @(posedge i_clk); #1; n++;
    end
    check("valid_wait_bound", int'(n >= 400), 0);
    sx = int'(o_x); sy = int'(o_y);
    cnt0 = int'(o_count);
    for (int k = 0; k < 5; k++) begin
      @(posedge i_clk); #1;
      check("hold_valid", int'(o_valid), 1);
      check("hold_x", int'(o_x), sx);
      check("hold_y", int'(o_y), sy);
      check("hold_ready", int'(o_ready), 0);
    end
    rdy_val = 1'b1;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    check("release_count", int'(o_count), (cnt0 + 1) & 16'hFFFF);
    check("release_ready", int'(o_ready), 1);
    check("release_valid", int'(o_valid), 0);
    rdy_mode = 1'b1;
    drain();

    // Timeout: core never answers.
    core_disable = 1'b1;
    cnt0 = int'(o_count);
    send(5, 5, 0, 0);
    wait_start();
    @(posedge i_clk); #1;
    n = 0;
    while (!o_error && n < 200) begin
      @(posedge i_clk); #1; n++;
    end
    check("timeout_cycles", n, TO);
    check("timeout_ready", int'(o_ready), 1);
    check("timeout_count", int'(o_count), cnt0);
    check("timeout_valid", int'(o_valid), 0);
    repeat (3) @(posedge i_clk);
    #1 check("error_sticky", int'(o_error), 1);

    // Asynchronous reset while waiting on the core.
    send(3, 4, 0, 0);
    wait_start();
    repeat (5) @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    cnt_base = delivered;
    #1 check_reset("rst_wait");
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    core_disable = 1'b0;
    @(posedge i_clk); #1;

    // Normal operation resumes after reset.
    send(-30, 11, -1000000, 1);
    drain();
    check("count_after_reset", int'(o_count), 1);
    check("error_after_reset", int'(o_error), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rotate_scheduler.md
# rotate_scheduler

Front-end sequencer for the CORDIC rotation core. It accepts points with full-circle angles on a valid/ready stream and folds each angle into the ±π/2 range the core supports. It issues one core start per point, captures the result in the single cycle the core presents it, and holds that result on a backpressured output stream. It sits between the point source (sprite/vertex buffer) and the rotation core, and owns all flow control the core lacks.

## Interface
- DATA_WIDTH, 7: signed integer width of point coordinates.
- ANGLE_WIDTH, 23: signed input angle width; units 2^-20 rad.
- CORE_ANGLE_WIDTH, 22: signed angle width driven to the core; same units.
- TIMEOUT, 32: max cycles allowed in S_WAIT before aborting.
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_valid  in  1  input point valid.
- o_ready  out  1  input ready; high only in S_IDLE.
- i_x, i_y  in  DATA_WIDTH  signed input point.
- i_angle  in  ANGLE_WIDTH  signed rotation angle, nominal range [-PI_Q, PI_Q], where PI_Q = 3294199.
- o_cordic_start  out  1  one-cycle start pulse to the core.
- o_cordic_x, o_cordic_y  out  DATA_WIDTH  folded operands; registered and stable from S_ISSUE until the next accept.
- o_cordic_angle  out  CORE_ANGLE_WIDTH  folded angle, in [-HPI_Q, HPI_Q], where HPI_Q = 1647099.
- i_cordic_x, i_cordic_y  in  DATA_WIDTH  core result; valid only while i_cordic_done is high.
- i_cordic_done  in  1  core completion pulse (one cycle).
- o_valid  out  1  output point valid.
- i_ready  in  1  downstream ready.
- o_x, o_y  out  DATA_WIDTH  rotated point, held while o_valid is high.
- o_count  out  16  number of points delivered (o_valid & i_ready); wraps from 65535 to 0.
- o_error  out  1  sticky; set on timeout; cleared only by reset.

## Operation
- States: S_IDLE, S_ISSUE, S_WAIT, S_OUT.
- S_IDLE: o_ready = 1. When i_valid is high, register the folded operands and go to S_ISSUE.
- Angle handling at accept:
  - Clamp i_angle to [-PI_Q, PI_Q].
  - If a > HPI_Q: angle = a - PI_Q; negate x and y.
  - If a < -HPI_Q: angle = a + PI_Q; negate x and y.
  - Otherwise pass x, y and a unchanged.
  - a = ±HPI_Q exactly is not folded.
- Negation saturates: -(-2^(DATA_WIDTH-1)) = 2^(DATA_WIDTH-1) - 1, e.g. -64 becomes 63.
- S_ISSUE: o_cordic_start = 1 for exactly one cycle, then go to S_WAIT.
- S_WAIT:
  - On i_cordic_done, capture i_cordic_x and i_cordic_y into o_x and o_y, then go to S_OUT.
  - If the timeout counter reaches TIMEOUT first, set o_error, drop the point and return to S_IDLE.
  - The timeout counter resets on entry to S_WAIT.
- S_OUT: o_valid = 1. When i_ready is high, increment o_count and go to S_IDLE.
- i_cordic_done outside S_WAIT is ignored.
- Arithmetic: angle fold is computed at ANGLE_WIDTH+1 bits, then truncated to CORE_ANGLE_WIDTH (the result always fits).

## Timing
- Reset values: state S_IDLE; o_ready 1; o_valid 0; o_cordic_start 0; o_cordic_x, o_cordic_y and o_cordic_angle 0; o_x and o_y 0; o_count 0; o_error 0.
- Accept at cycle t: o_cordic_start is high at t+1.
- With the standard 16-iteration core, done arrives at t+18 and o_valid rises at t+19.
- Minimum throughput: one point per 20 cycles when i_ready is held high.
- o_ready is registered from state, so there is no combinational path from i_ready or i_valid.
- A point is accepted only in S_IDLE. Same-cycle deliver-and-accept is not supported: S_OUT always passes through S_IDLE.
- Done in the same cycle the timeout is reached: done wins, the point is captured and no error is set.
- Reset mid-operation: return immediately to reset values. The core is reset on the same i_rst_n, so no stale done is possible.

## Test plan
- Accept (40,0) with angle 0 -> core sees (40,0,0); output ≈(40,0); o_count = 1.
- Accept (40,0) with angle 3294199 (π) -> core sees (-40,0,0); output (-40,0).
- Accept (10,20) with angle -2097152 (-2.0 rad) -> core sees (-10,-20,1197047); output matches a floating-point rotation within ±1 LSB.
- Accept (-64,5) with angle 3294199 -> core sees (63,-5,0), confirming saturated negation.
- Hold i_ready low for 5 cycles in S_OUT -> o_valid stays high, o_x/o_y stay stable, o_ready stays 0; then i_ready = 1 -> o_count increments and o_ready = 1 on the next cycle.
- Core model never asserts done -> o_error = 1 exactly TIMEOUT cycles after entering S_WAIT; returns to S_IDLE; o_count unchanged.
- Assert i_rst_n low during S_WAIT -> all outputs return to reset values asynchronously.
